// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary as a two-entry elastic buffer (main + skid).
// ready_ex_mem_o and valid_ex_mem_o are decoded straight from state flops.
package tinyriscv_pkg;
    typedef logic [31:0] InstBus;
    typedef logic [31:0] InstAddrBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [31:0] RegBus;
    typedef logic [31:0] MemAddrBus;
    typedef logic [2:0]  Hold_Flag_Bus;

    localparam Hold_Flag_Bus Hold_None  = 3'b000;
    localparam Hold_Flag_Bus Pipe_Clear = 3'b111;
    localparam InstBus       INST_NOP   = 32'h0000_0013;
endpackage

module ex_mem_skid
    import tinyriscv_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_ex_i,
    output logic         ready_ex_mem_o,
    input  Hold_Flag_Bus hold_flag_i,
    input  InstBus       inst_i,
    output InstBus       inst_o,
    input  InstAddrBus   inst_addr_i,
    output InstAddrBus   inst_addr_o,
    input  logic         reg_we_i,
    output logic         reg_we_o,
    input  RegAddrBus    reg_waddr_i,
    output RegAddrBus    reg_waddr_o,
    input  RegBus        reg_wdata_i,
    output RegBus        reg_wdata_o,
    input  logic         mem_req_i,
    output logic         mem_req_o,
    input  logic         mem_we_i,
    output logic         mem_we_o,
    input  MemAddrBus    mem_addr_i,
    output MemAddrBus    mem_addr_o,
    input  RegBus        mem_wdata_i,
    output RegBus        mem_wdata_o,
    input  logic [3:0]   mem_be_i,
    output logic [3:0]   mem_be_o,
    input  logic         csr_we_i,
    output logic         csr_we_o,
    input  MemAddrBus    csr_waddr_i,
    output MemAddrBus    csr_waddr_o,
    input  RegBus        csr_wdata_i,
    output RegBus        csr_wdata_o,
    output logic         valid_ex_mem_o,
    input  logic         ready_mem_i
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready never looks at valid.
    typedef struct packed {
        InstBus     inst;
        InstAddrBus inst_addr;
        logic       reg_we;
        RegAddrBus  reg_waddr;
        RegBus      reg_wdata;
        logic       mem_req;
        logic       mem_we;
        MemAddrBus  mem_addr;
        RegBus      mem_wdata;
        logic [3:0] mem_be;
        logic       csr_we;
        MemAddrBus  csr_waddr;
        RegBus      csr_wdata;
    } entry_t;

    // Bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic accept;
    logic retire;
    logic flush;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_entry = '{
        inst:      inst_i,
        inst_addr: inst_addr_i,
        reg_we:    reg_we_i,
        reg_waddr: reg_waddr_i,
        reg_wdata: reg_wdata_i,
        mem_req:   mem_req_i,
        mem_we:    mem_we_i,
        mem_addr:  mem_addr_i,
        mem_wdata: mem_wdata_i,
        mem_be:    mem_be_i,
        csr_we:    csr_we_i,
        csr_waddr: csr_waddr_i,
        csr_wdata: csr_wdata_i
    };

    assign ready_ex_mem_o = ~state_q[1];
    assign valid_ex_mem_o = state_q[0];
    assign accept         = valid_ex_i & ready_ex_mem_o;
    assign retire         = valid_ex_mem_o & ready_mem_i;
    assign flush          = (hold_flag_i == Pipe_Clear);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !retire) begin
                    state_d = FULL;
                end else if (!accept && retire) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (retire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & retire;
                    load_skid    = accept & ~retire;
                end
                FULL: load_main_skid = retire;
                default: ;
            endcase
        end
    end

    // Payload flops hold their value unless a load is explicitly requested.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q      <= '0;
            main_q.inst <= INST_NOP;
            skid_q      <= '0;
        end else begin
            if (flush) begin
                main_q.inst <= INST_NOP;
            end else if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Side-effect enables are masked so a stale main entry never fires.
    assign inst_o      = main_q.inst;
    assign inst_addr_o = main_q.inst_addr;
    assign reg_we_o    = main_q.reg_we & valid_ex_mem_o;
    assign reg_waddr_o = main_q.reg_waddr;
    assign reg_wdata_o = main_q.reg_wdata;
    assign mem_req_o   = main_q.mem_req & valid_ex_mem_o;
    assign mem_we_o    = main_q.mem_we & valid_ex_mem_o;
    assign mem_addr_o  = main_q.mem_addr;
    assign mem_wdata_o = main_q.mem_wdata;
    assign mem_be_o    = main_q.mem_be;
    assign csr_we_o    = main_q.csr_we & valid_ex_mem_o;
    assign csr_waddr_o = main_q.csr_waddr;
    assign csr_wdata_o = main_q.csr_wdata;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed scenarios plus random valid/ready traffic,
// checked by a queue-based model of a two-deep in-order buffer.
module tb_ex_mem_skid;
    import tinyriscv_pkg::*;

    localparam int PW = 237;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_ex_i;
    logic         ready_ex_mem_o;
    Hold_Flag_Bus hold_flag_i;
    InstBus       inst_i, inst_o;
    InstAddrBus   inst_addr_i, inst_addr_o;
    logic         reg_we_i, reg_we_o;
    RegAddrBus    reg_waddr_i, reg_waddr_o;
    RegBus        reg_wdata_i, reg_wdata_o;
    logic         mem_req_i, mem_req_o;
    logic         mem_we_i, mem_we_o;
    MemAddrBus    mem_addr_i, mem_addr_o;
    RegBus        mem_wdata_i, mem_wdata_o;
    logic [3:0]   mem_be_i, mem_be_o;
    logic         csr_we_i, csr_we_o;
    MemAddrBus    csr_waddr_i, csr_waddr_o;
    RegBus        csr_wdata_i, csr_wdata_o;
    logic         valid_ex_mem_o;
    logic         ready_mem_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] exp_q[$];
    logic          nop_expected;
    logic [PW-1:0] in_vec;
    logic [PW-1:0] out_vec;

    ex_mem_skid dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_ex_i     (valid_ex_i),
        .ready_ex_mem_o (ready_ex_mem_o),
        .hold_flag_i    (hold_flag_i),
        .inst_i         (inst_i),
        .inst_o         (inst_o),
        .inst_addr_i    (inst_addr_i),
        .inst_addr_o    (inst_addr_o),
        .reg_we_i       (reg_we_i),
        .reg_we_o       (reg_we_o),
        .reg_waddr_i    (reg_waddr_i),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_i    (reg_wdata_i),
        .reg_wdata_o    (reg_wdata_o),
        .mem_req_i      (mem_req_i),
        .mem_req_o      (mem_req_o),
        .mem_we_i       (mem_we_i),
        .mem_we_o       (mem_we_o),
        .mem_addr_i     (mem_addr_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_i    (mem_wdata_i),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_i       (mem_be_i),
        .mem_be_o       (mem_be_o),
        .csr_we_i       (csr_we_i),
        .csr_we_o       (csr_we_o),
        .csr_waddr_i    (csr_waddr_i),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_i    (csr_wdata_i),
        .csr_wdata_o    (csr_wdata_o),
        .valid_ex_mem_o (valid_ex_mem_o),
        .ready_mem_i    (ready_mem_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign in_vec  = {inst_i, inst_addr_i, reg_we_i, reg_waddr_i, reg_wdata_i, mem_req_i,
                      mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i, csr_we_i, csr_waddr_i,
                      csr_wdata_i};
    assign out_vec = {inst_o, inst_addr_o, reg_we_o, reg_waddr_o, reg_wdata_o, mem_req_o,
                      mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, csr_we_o, csr_waddr_o,
                      csr_wdata_o};

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic r, input logic do_flush, input logic flags_on);
        Hold_Flag_Bus h;
        @(posedge clk);
        #1;
        h = Hold_Flag_Bus'($urandom_range(0, 7));
        if (h == Pipe_Clear) h = Hold_None;
        if (do_flush) h = Pipe_Clear;
        valid_ex_i  = v;
        ready_mem_i = r;
        hold_flag_i = h;
        inst_i      = $urandom;
        inst_addr_i = $urandom;
        reg_we_i    = flags_on | 1'($urandom_range(0, 1));
        reg_waddr_i = 5'($urandom_range(0, 31));
        reg_wdata_i = $urandom;
        mem_req_i   = flags_on | 1'($urandom_range(0, 1));
        mem_we_i    = flags_on | 1'($urandom_range(0, 1));
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_be_i    = 4'($urandom_range(0, 15));
        csr_we_i    = flags_on | 1'($urandom_range(0, 1));
        csr_waddr_i = $urandom;
        csr_wdata_i = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, PW'(valid_ex_mem_o), PW'(1'b0));
        check({tag, "_ready"}, PW'(ready_ex_mem_o), PW'(1'b1));
        check({tag, "_inst"},  PW'(inst_o), PW'(INST_NOP));
        check({tag, "_rest"},  {32'h0, out_vec[PW-33:0]}, '0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Model: the block holds an ordered list of at most two entries.
    always @(negedge clk) begin
        logic model_ready;
        logic acc;
        logic ret;
        if (rst) begin
            exp_q.delete();
            nop_expected = 1'b1;
        end else begin
            model_ready = (exp_q.size() < 2);
            check("valid_o", PW'(valid_ex_mem_o), PW'(exp_q.size() > 0));
            check("ready_o", PW'(ready_ex_mem_o), PW'(model_ready));
            if (exp_q.size() > 0) begin
                check("payload", out_vec, exp_q[0]);
            end else begin
                check("gated_we", PW'({reg_we_o, mem_req_o, mem_we_o, csr_we_o}), '0);
                if (nop_expected) check("nop_inst", PW'(inst_o), PW'(INST_NOP));
            end
            acc = valid_ex_i & model_ready;
            ret = (exp_q.size() > 0) & ready_mem_i;
            if (ret) void'(exp_q.pop_front());
            if (hold_flag_i == Pipe_Clear) begin
                exp_q.delete();
                nop_expected = 1'b1;
            end else if (acc) begin
                exp_q.push_back(in_vec);
                nop_expected = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        valid_ex_i = 1'b0; ready_mem_i = 1'b0; hold_flag_i = Hold_None;
        inst_i = '0; inst_addr_i = '0; reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
        csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Stream of three, last one with all side-effect flags set, then drain.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill, keep offering, then release.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Flush while full with a new entry offered.
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_valid", PW'(valid_ex_mem_o), PW'(1'b0));
        check("flush_inst",  PW'(inst_o), PW'(INST_NOP));
        check("flush_ready", PW'(ready_ex_mem_o), PW'(1'b1));
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset pulse while full, between clock edges.
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        #4 rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        repeat (4000) begin
            drive(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 3), 1'b0);
        end

        repeat (6) drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("drained", PW'(valid_ex_mem_o), PW'(1'b0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
